// File: rtl/qc_sraa_pkg.sv
// qc_sraa_pkg
// Shared definitions for the QC-LDPC shift-register-add-accumulate encoder core:
//   - state_t   : controller states (IDLE, LOAD_G, ACCUM, OUTPUT)
//   - QC_B, QC_C, QC_K_BLKS : default circulant size, parallel parity columns
//                             and info circulant rows per codeword
//   - cnt_width : width of a counter that must hold the values 0..n-1,
//                 never narrower than one bit
package qc_sraa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_G = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int QC_B      = 88;
  localparam int QC_C      = 4;
  localparam int QC_K_BLKS = 8;

  // A one-value counter still needs a physical bit, hence the floor of 1.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/qc_sraa_lane.sv
// qc_sraa_lane
// One parity circulant column: a B-bit cyclic shift register holding the
// current generator row, and a B-bit AND-XOR accumulator.
// Ports:
//   clk      in   clock, rising edge
//   clear_n  in   synchronous active-low reset (clears row and accumulator)
//   clr      in   clear accumulator (start of a new codeword)
//   load     in   load load_row into the shift register
//   load_row in   B-bit generator circulant first row
//   en       in   accumulate bit_in and rotate the row right by one
//   bit_in   in   serial information bit
//   acc      out  accumulated parity bits of this column
module qc_sraa_lane
  import qc_sraa_pkg::*;
#(
  parameter int B = QC_B
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         clr,
  input  logic         load,
  input  logic [B-1:0] load_row,
  input  logic         en,
  input  logic         bit_in,
  output logic [B-1:0] acc
);

  logic [B-1:0] shreg;

  // The row is applied before it rotates, so the first bit of each block
  // sees the row exactly as loaded.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      shreg <= '0;
      acc   <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc ^ (shreg & {B{bit_in}});
      end

      if (load) begin
        shreg <= load_row;
      end else if (en) begin
        shreg <= {shreg[0], shreg[B-1:1]};
      end
    end
  end

endmodule

// File: rtl/qc_sraa_encoder_core.sv
// qc_sraa_encoder_core
// Parametrised SRAA stage of the QC-LDPC encoder. C parity circulant columns
// of B bits are accumulated in parallel while K_BLKS info circulant rows are
// sequenced through generator-row load, bit-serial accumulate and parity
// hand-off.
// Ports:
//   clk        in   clock, rising edge
//   clear_n    in   synchronous active-low reset
//   start      in   begin a codeword (honoured only when idle)
//   g_data     in   C*B generator first rows, column c at [c*B +: B]
//   g_valid    in   g_data valid
//   g_ready    out  core accepts g_data
//   info_bit   in   serial information bit
//   info_valid in   info_bit valid
//   info_ready out  core accepts info_bit
//   par_data   out  accumulated parity, column c at [c*B +: B]
//   par_valid  out  par_data valid
//   par_ready  in   downstream accepts parity
//   busy       out  high whenever not idle
// Optional build macro QC_SRAA_INFO_ECHO_EN adds:
//   sys_bit    out  each accepted info bit, one cycle after its transfer
//   sys_valid  out  qualifies sys_bit
module qc_sraa_encoder_core
  import qc_sraa_pkg::*;
#(
  parameter int B      = QC_B,
  parameter int C      = QC_C,
  parameter int K_BLKS = QC_K_BLKS
) (
  input  logic           clk,
  input  logic           clear_n,
  input  logic           start,
  input  logic [C*B-1:0] g_data,
  input  logic           g_valid,
  output logic           g_ready,
  input  logic           info_bit,
  input  logic           info_valid,
  output logic           info_ready,
  output logic [C*B-1:0] par_data,
  output logic           par_valid,
  input  logic           par_ready,
  output logic           busy
`ifdef QC_SRAA_INFO_ECHO_EN
  ,
  output logic           sys_bit,
  output logic           sys_valid
`endif
);

  localparam int BIT_W = cnt_width(B);
  localparam int BLK_W = cnt_width(K_BLKS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(B - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(K_BLKS - 1);

  state_t           state;
  state_t           state_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic             acc_clr;
  logic             row_load;
  logic             bit_en;
  logic             blk_end;

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshakes are decoded from the registered state only, so the ready
  // outputs never depend combinationally on any valid input.
  assign g_ready    = (state == LOAD_G);
  assign info_ready = (state == ACCUM);
  assign par_valid  = (state == OUTPUT);
  assign busy       = (state != IDLE);
  assign blk_end    = (bit_cnt == BIT_LAST);

  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    row_load   = 1'b0;
    bit_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr    = 1'b1;
          state_next = LOAD_G;
        end
      end
      LOAD_G: begin
        if (g_valid) begin
          row_load   = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (info_valid) begin
          bit_en = 1'b1;
          if (blk_end) begin
            state_next = (blk_cnt == BLK_LAST) ? OUTPUT : LOAD_G;
          end
        end
      end
      OUTPUT: begin
        if (par_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt returns to zero at the end of each block rather than stepping to
  // B, which keeps it inside $clog2(B) bits for power-of-two B.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      bit_cnt <= '0;
      blk_cnt <= '0;
    end else if (acc_clr) begin
      bit_cnt <= '0;
      blk_cnt <= '0;
    end else if (row_load) begin
      bit_cnt <= '0;
    end else if (bit_en) begin
      if (blk_end) begin
        bit_cnt <= '0;
        if (blk_cnt != BLK_LAST) begin
          blk_cnt <= blk_cnt + BLK_W'(1);
        end
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

  // One lane per parity column; each lane's accumulator drives its slice of
  // par_data directly and is retained after hand-off until the next start.
  for (genvar c = 0; c < C; c++) begin : g_lane
    qc_sraa_lane #(
      .B(B)
    ) u_lane (
      .clk      (clk),
      .clear_n  (clear_n),
      .clr      (acc_clr),
      .load     (row_load),
      .load_row (g_data[c*B +: B]),
      .en       (bit_en),
      .bit_in   (info_bit),
      .acc      (par_data[c*B +: B])
    );
  end

`ifdef QC_SRAA_INFO_ECHO_EN
  // Systematic echo: the bit is only updated on a transfer, and sys_valid
  // marks exactly the cycle after each accepted bit.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sys_bit   <= 1'b0;
      sys_valid <= 1'b0;
    end else begin
      sys_valid <= bit_en;
      if (bit_en) begin
        sys_bit <= info_bit;
      end
    end
  end
`endif

endmodule
